// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 decryption engine: FSM state encoding,
// fixed geometry constants and the key byte selector.
package arc4_pkg;

  localparam int unsigned KEY_BYTES  = 3;
  localparam int unsigned SBOX_DEPTH = 256;
  localparam logic [1:0]  KEY_LAST   = 2'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_KSA_RDI,
    S_KSA_RDJ,
    S_KSA_WRI,
    S_KSA_WRJ,
    S_PRGA_LEN,
    S_PRGA_RDI,
    S_PRGA_RDJ,
    S_PRGA_WRI,
    S_PRGA_WRJ,
    S_PRGA_RDP,
    S_PRGA_OUT,
    S_DONE
  } state_t;

  // Byte 0 is the most significant byte of the 24-bit key.
  function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
    case (idx)
      2'd0:    key_byte = key[23:16];
      2'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  endfunction

endpackage

// File: rtl/arc4_sbox.sv
// 256x8 single-port state array for ARC4.
// Ports: clk; addr (shared read/write address); we (write enable);
// wdata (write data); rdata (registered read data, valid one cycle after addr).
// A read during a write returns the old contents. No reset.
module arc4_sbox
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] addr,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [SBOX_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/arc4.sv
// ARC4 decryption engine with a 24-bit key.
// Ports: clk; rst_n (async reset, active HIGH despite the name);
// en/rdy start handshake; key (latched on accepted start);
// ct_addr/ct_rddata: length-prefixed ciphertext memory, 1-cycle read latency;
// pt_addr/pt_wrdata/pt_wren: length-prefixed plaintext memory writes;
// pt_rddata is not used.
module arc4
  import arc4_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  ct_addr,
  input  logic [7:0]  ct_rddata,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  pt_wrdata,
  output logic        pt_wren
);

  state_t      state, state_nx;
  logic [23:0] key_q;
  logic [7:0]  i, j, k, len, si, sj, ct_byte;
  logic [1:0]  kidx;
  logic [7:0]  s_addr, s_wdata, s_rdata;
  logic        s_we;
  logic [7:0]  i_inc, j_ksa, j_prga;
  logic        unused_pt;

  assign unused_pt = ^pt_rddata;

  arc4_sbox u_sbox (
    .clk   (clk),
    .addr  (s_addr),
    .we    (s_we),
    .wdata (s_wdata),
    .rdata (s_rdata)
  );

  assign rdy    = (state == S_IDLE);
  assign i_inc  = i + 8'd1;
  assign j_ksa  = j + s_rdata + key_byte(key_q, kidx);
  assign j_prga = j + s_rdata;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Each swap takes four cycles on the single-port array: read S[i],
  // read S[j] (address from the freshly computed j), write S[i], write S[j].
  always_comb begin
    state_nx = state;
    s_addr   = i;
    s_we     = 1'b0;
    s_wdata  = i;
    case (state)
      S_IDLE:     if (en) state_nx = S_INIT;
      S_INIT: begin
        s_we = 1'b1;
        if (i == 8'hff) state_nx = S_KSA_RDI;
      end
      S_KSA_RDI:  state_nx = S_KSA_RDJ;
      S_KSA_RDJ: begin
        s_addr   = j_ksa;
        state_nx = S_KSA_WRI;
      end
      S_KSA_WRI: begin
        s_we     = 1'b1;
        s_wdata  = s_rdata;
        state_nx = S_KSA_WRJ;
      end
      S_KSA_WRJ: begin
        s_addr   = j;
        s_we     = 1'b1;
        s_wdata  = si;
        state_nx = (i == 8'hff) ? S_PRGA_LEN : S_KSA_RDI;
      end
      S_PRGA_LEN: state_nx = (ct_rddata == 8'd0) ? S_DONE : S_PRGA_RDI;
      S_PRGA_RDI: begin
        s_addr   = i_inc;
        state_nx = S_PRGA_RDJ;
      end
      S_PRGA_RDJ: begin
        s_addr   = j_prga;
        state_nx = S_PRGA_WRI;
      end
      S_PRGA_WRI: begin
        s_we     = 1'b1;
        s_wdata  = s_rdata;
        state_nx = S_PRGA_WRJ;
      end
      S_PRGA_WRJ: begin
        s_addr   = j;
        s_we     = 1'b1;
        s_wdata  = si;
        state_nx = S_PRGA_RDP;
      end
      S_PRGA_RDP: begin
        s_addr   = si + sj;
        state_nx = S_PRGA_OUT;
      end
      S_PRGA_OUT: state_nx = (k == len) ? S_DONE : S_PRGA_RDI;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      key_q     <= '0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      len       <= '0;
      si        <= '0;
      sj        <= '0;
      ct_byte   <= '0;
      kidx      <= '0;
      ct_addr   <= '0;
      pt_addr   <= '0;
      pt_wrdata <= '0;
      pt_wren   <= 1'b0;
    end else begin
      pt_wren <= 1'b0;
      case (state)
        S_IDLE: if (en) begin
          key_q   <= key;
          i       <= '0;
          j       <= '0;
          kidx    <= '0;
          // Held at 0 through INIT/KSA so the length byte is ready in PRGA_LEN.
          ct_addr <= '0;
        end
        S_INIT:    i <= i_inc;
        S_KSA_RDJ: begin
          si <= s_rdata;
          j  <= j_ksa;
        end
        S_KSA_WRJ: begin
          i    <= i_inc;
          kidx <= (kidx == KEY_LAST) ? 2'd0 : kidx + 2'd1;
        end
        S_PRGA_LEN: begin
          len       <= ct_rddata;
          pt_addr   <= '0;
          pt_wrdata <= ct_rddata;
          pt_wren   <= 1'b1;
          i         <= '0;
          j         <= '0;
          k         <= 8'd1;
        end
        S_PRGA_RDI: begin
          i       <= i_inc;
          // Issued early so ct[k] is back by the S[i] write cycle.
          ct_addr <= k;
        end
        S_PRGA_RDJ: begin
          si <= s_rdata;
          j  <= j_prga;
        end
        S_PRGA_WRI: begin
          sj      <= s_rdata;
          ct_byte <= ct_rddata;
        end
        S_PRGA_OUT: begin
          pt_addr   <= k;
          pt_wrdata <= s_rdata ^ ct_byte;
          pt_wren   <= 1'b1;
          if (k != len) k <= k + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4.sv
module tb_arc4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  ct_addr, ct_rddata, pt_addr, pt_rddata, pt_wrdata;
  logic        pt_wren;

  logic [7:0]  ct_mem [256];
  logic [15:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          max_ct   = 0;

  always #5 clk = ~clk;

  arc4 dut (
    .clk       (clk),
    .rst_n     (rst),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
  );

  assign pt_rddata = 8'hA5;

  always @(posedge clk) ct_rddata <= ct_mem[ct_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every PT write is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (!rdy && int'(ct_addr) > max_ct) max_ct = int'(ct_addr);
      if (pt_wren) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pt_write_unexpected: got addr %0h data %0h expected no write", pt_addr, pt_wrdata);
        end else begin
          check("pt_write{addr,data}", {16'h0, pt_addr, pt_wrdata}, {16'h0, exp_q.pop_front()});
        end
      end
    end
  end

  // Reference RC4: plain key schedule + keystream over an int-indexed array.
  task automatic model_push(input logic [23:0] k, input int len);
    int s [256];
    int kb [3];
    int a, b, t;
    logic [7:0] pt;
    kb[0] = int'(k[23:16]); kb[1] = int'(k[15:8]); kb[2] = int'(k[7:0]);
    for (int n = 0; n < 256; n++) s[n] = n;
    b = 0;
    for (int n = 0; n < 256; n++) begin
      b = (b + s[n] + kb[n % 3]) % 256;
      t = s[n]; s[n] = s[b]; s[b] = t;
    end
    exp_q.push_back({8'h00, 8'(len)});
    a = 0; b = 0;
    for (int n = 1; n <= len; n++) begin
      a = (a + 1) % 256;
      b = (b + s[a]) % 256;
      t = s[a]; s[a] = s[b]; s[b] = t;
      pt = 8'(s[(s[a] + s[b]) % 256]) ^ ct_mem[n];
      exp_q.push_back({8'(n), pt});
    end
  endtask

  task automatic wait_rdy(input string name);
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (rdy) begin
        check(name, 32'(rdy), 32'd1);
        return;
      end
    end
    check({name, "_timeout"}, 32'(rdy), 32'd1);
  endtask

  task automatic finish_checks(input string name, input int len);
    check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_ct_addr_max<=L"}, 32'(max_ct <= len), 32'd1);
    exp_q.delete();
  endtask

  task automatic do_run(input string name, input logic [23:0] k, input int len);
    @(negedge clk);
    key = k; en = 1'b1; max_ct = 0;
    @(posedge clk); #1 en = 1'b0;
    wait_rdy(name);
    finish_checks(name, len);
  endtask

  task automatic directed(input string name, input logic [23:0] k, input int len,
                          input logic [127:0] ct_vec, input logic [127:0] pt_vec);
    ct_mem[0] = 8'(len);
    exp_q.push_back({8'h00, 8'(len)});
    for (int n = 1; n <= len; n++) begin
      ct_mem[n] = ct_vec[8*(len-n) +: 8];
      exp_q.push_back({8'(n), pt_vec[8*(len-n) +: 8]});
    end
    do_run(name, k, len);
  endtask

  task automatic random_run(input string name, input int len);
    logic [23:0] k;
    k = 24'($urandom);
    ct_mem[0] = 8'(len);
    for (int n = 1; n <= len; n++) ct_mem[n] = 8'($urandom);
    model_push(k, len);
    do_run(name, k, len);
  endtask

  initial begin
    logic [23:0] k1, k2;
    rst = 1'b1; en = 1'b0; key = '0;
    for (int n = 0; n < 256; n++) ct_mem[n] = 8'h00;
    #2;
    check("reset_rdy", 32'(rdy), 32'd1);
    check("reset_pt_wren", 32'(pt_wren), 32'd0);
    check("reset_ct_addr", 32'(ct_addr), 32'd0);
    check("reset_pt_addr", 32'(pt_addr), 32'd0);
    check("reset_pt_wrdata", 32'(pt_wrdata), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_after_release", 32'(rdy), 32'd1);

    directed("wikipedia", 24'h4B6579, 9, 128'hBBF316E8D940AF0AD3, 128'h506C61696E74657874);
    directed("zero_key", 24'h000000, 4, 128'h00000000, 128'hDE188941);
    directed("empty_msg", 24'h123456, 0, 128'h0, 128'h0);

    // en held high, key changed mid-run, then an immediate second run.
    k1 = 24'h4B6579; k2 = 24'($urandom);
    ct_mem[0] = 8'd12;
    for (int n = 1; n <= 12; n++) ct_mem[n] = 8'($urandom);
    model_push(k1, 12);
    model_push(k2, 12);
    max_ct = 0;
    @(negedge clk);
    key = k1; en = 1'b1;
    @(posedge clk); #1 key = k2;
    wait_rdy("b2b_first");
    @(posedge clk); #1 en = 1'b0;
    check("b2b_restarted", 32'(rdy), 32'd0);
    wait_rdy("b2b_second");
    finish_checks("b2b", 12);

    // Reset partway through the key schedule.
    @(negedge clk);
    key = 24'hABCDEF; en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    repeat (400) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_rdy", 32'(rdy), 32'd1);
    check("abort_pt_wren", 32'(pt_wren), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_stays_idle", 32'(rdy), 32'd1);

    random_run("rand_a", int'($urandom_range(1, 40)));
    random_run("rand_b", int'($urandom_range(1, 40)));
    random_run("rand_c", 1);
    random_run("rand_max", 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
